prog_loader: RTL
================

# prog_loader

Program loader that receives a framed byte stream over a valid/ready handshake and writes it into the 256×8 program RAM through its synchronous write port. After the write it reads the image back through the RAM's combinational read port to verify it. It sits between the host byte source (e.g. UART receiver) and the RAM. While a load is in progress it holds the CPU off via `cpu_hold`.

## Interface
- `ADDR_W`, 8, RAM address width; addresses wrap modulo 2^ADDR_W
- `DATA_W`, 8, RAM and stream byte width
- `SYNC_BYTE`, 8'hA5, frame start marker
- `clk`  in  1  single system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  stream byte valid
- `in_data`  in  DATA_W  stream byte
- `in_ready`  out  1  loader accepts byte; a transfer occurs when `in_valid && in_ready` at a rising edge
- `we`  out  1  RAM write enable, registered
- `w_addr`  out  ADDR_W  RAM write address, registered
- `w_data`  out  DATA_W  RAM write data, registered
- `r_addr`  out  ADDR_W  RAM read address, registered
- `r_data`  in  DATA_W  RAM read data, combinational from `r_addr`
- `cpu_hold`  out  1  high while a frame is being loaded or verified
- `done`  out  1  one-cycle pulse: frame written and verified
- `error`  out  1  sticky; cleared when the next SYNC_BYTE is accepted

## Operation
- Frame format: SYNC, ADDR, LEN, LEN+1 data bytes (N = 1..256), CHK. Requirement: (ADDR + LEN + Σdata + CHK) mod 256 == 0.
- IDLE: `in_ready`=1. Non-SYNC bytes are accepted and discarded. On SYNC: go to ADDR, set `cpu_hold`, clear `error`.
- ADDR: latch the base address. Go to LEN.
- LEN: latch the count, N = LEN+1. Go to DATA.
- DATA: byte i (0-based) is written to address (base+i) mod 256. A running header+data sum and a separate data-only sum accumulate. After N bytes, go to CHK.
- CHK: if the frame sum including CHK ≠ 0, go to ERR. Otherwise go to VERIFY.
- VERIFY: `in_ready`=0. For one cycle per byte, drive `r_addr`=base+j and add the `r_data` sampled that cycle. After N reads, go to CMP.
- CMP: if the readback sum equals the data sum, pulse `done`. Otherwise set `error`. Clear `cpu_hold` and return to IDLE.
- ERR: set `error`, clear `cpu_hold`, return to IDLE. RAM bytes already written are not rolled back.
- `in_ready`=1 in IDLE, ADDR, LEN, DATA and CHK; 0 in VERIFY and CMP.
- A SYNC_BYTE value inside ADDR, LEN, DATA or CHK is treated as ordinary data.

## Timing
- Reset values: `in_ready`, `we`, `cpu_hold`, `done`, `error` = 0; `w_addr`, `w_data`, `r_addr` = 0; state = IDLE. `in_ready` rises in the first cycle after reset deasserts.
- Write latency: a data byte accepted at edge t produces `we`=1 with the matching address and data during cycle t+1. `we` is high for exactly one cycle per byte.
- The last write completes before VERIFY starts, because the CHK byte transfer always comes at least one edge after the last data byte.
- CHK accepted at edge t:
  - VERIFY occupies cycles t+1 … t+N.
  - `done` or `error` rises in cycle t+N+1.
  - `cpu_hold` falls in the same cycle.
- Bad checksum: `error`=1 and `cpu_hold`=0 in cycle t+1, with no read cycles.
- Gaps in `in_valid` only stall the FSM. There is no timeout.
- Reset mid-frame aborts immediately to the reset values. `done` is not pulsed and partial RAM contents remain.

## Structure
- Package `prog_loader_pkg` holds:
  - the state enum (IDLE, ADDR, LEN, DATA, CHK, VERIFY, CMP, ERR)
  - the SYNC_BYTE default
  - the frame field count constant
- Single module, no sub-module. Checksum accumulators are local 8-bit registers with modulo-256 wrap. The byte counter is 9 bits so it can hold N=256.

## Test plan
- Basic load: A5 10 02 11 22 33 88 -> writes 11@10, 22@11, 33@12, one `we` each. `done` pulses 4 cycles after CHK. `cpu_hold` is high from the SYNC edge until `done`.
- Address wrap: A5 FE 03 01 02 03 04 F5 -> writes 01@FE, 02@FF, 03@00, 04@01. `done` pulses, `error`=0.
- Bad checksum: the basic-load frame with CHK=89 -> three writes occur, then `error`=1 in the cycle after CHK, no VERIFY reads, `done` never pulses.
- Verify mismatch: the RAM model returns a corrupted byte at 11 during readback -> `error`=1 in cycle t+4, `done` stays 0. The next SYNC clears `error`.
- Stream robustness: garbage 00 FF 5A before the basic-load frame, with `in_valid` toggling every other cycle -> the result is identical to basic load. `in_ready`=0 throughout VERIFY.
- Reset mid-DATA: assert `rst` after the second data byte -> all outputs return to their reset values at once, no `done`. A following full frame loads correctly.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the framed program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE, ADDR, LEN, DATA, CHK, VERIFY, CMP, ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Non-payload bytes per frame: SYNC, ADDR, LEN, CHK
  localparam int FRAME_OVERHEAD = 4;

endpackage

// File: rtl/prog_loader_if.sv
// Stream input, RAM write/read ports and CPU status lines of the loader.
interface prog_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    input  in_valid, in_data, r_data,
    output in_ready, we, w_addr, w_data, r_addr, cpu_hold, done, error
  );

  modport slave (
    output in_valid, in_data, r_data,
    input  in_ready, we, w_addr, w_data, r_addr, cpu_hold, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// Receives a SYNC/ADDR/LEN/data/CHK frame, writes the payload to program RAM,
// then reads it back and compares sums before releasing the CPU.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(SYNC_BYTE_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  prog_loader_if.master   bus
);

  // One extra bit so a full 2^ADDR_W byte payload fits in the count
  localparam int CNT_W = ADDR_W + 1;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  idx;
  logic [DATA_W-1:0] fsum;
  logic [DATA_W-1:0] dsum;
  logic [DATA_W-1:0] rsum;

  logic              xfer;
  logic              last;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] fsum_nxt;
  logic [DATA_W-1:0] rsum_nxt;

  assign xfer     = bus.in_valid && bus.in_ready;
  assign last     = (idx == cnt - CNT_W'(1));
  assign addr_i   = base + idx[ADDR_W-1:0];
  assign fsum_nxt = fsum + bus.in_data;
  assign rsum_nxt = rsum + bus.r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      base         <= '0;
      cnt          <= '0;
      idx          <= '0;
      fsum         <= '0;
      dsum         <= '0;
      rsum         <= '0;
      bus.in_ready <= 1'b0;
      bus.we       <= 1'b0;
      bus.w_addr   <= '0;
      bus.w_data   <= '0;
      bus.r_addr   <= '0;
      bus.cpu_hold <= 1'b0;
      bus.done     <= 1'b0;
      bus.error    <= 1'b0;
    end else begin
      bus.we   <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (xfer && bus.in_data == SYNC_BYTE) begin
            state        <= ADDR;
            bus.cpu_hold <= 1'b1;
            bus.error    <= 1'b0;
          end
        end
        ADDR: if (xfer) begin
          base  <= ADDR_W'(bus.in_data);
          fsum  <= bus.in_data;
          state <= LEN;
        end
        LEN: if (xfer) begin
          cnt   <= CNT_W'(bus.in_data) + CNT_W'(1);
          fsum  <= fsum_nxt;
          dsum  <= '0;
          idx   <= '0;
          state <= DATA;
        end
        DATA: if (xfer) begin
          bus.we     <= 1'b1;
          bus.w_addr <= addr_i;
          bus.w_data <= bus.in_data;
          fsum       <= fsum_nxt;
          dsum       <= dsum + bus.in_data;
          idx        <= idx + CNT_W'(1);
          if (last) state <= CHK;
        end
        CHK: if (xfer) begin
          bus.in_ready <= 1'b0;
          if (fsum_nxt != '0) begin
            bus.error    <= 1'b1;
            bus.cpu_hold <= 1'b0;
            state        <= ERR;
          end else begin
            idx        <= '0;
            rsum       <= '0;
            bus.r_addr <= base;
            state      <= VERIFY;
          end
        end
        VERIFY: begin
          // Verdict is decided on the last read so it shows up one cycle later
          rsum       <= rsum_nxt;
          idx        <= idx + CNT_W'(1);
          bus.r_addr <= addr_i + ADDR_W'(1);
          if (last) begin
            state        <= CMP;
            bus.cpu_hold <= 1'b0;
            if (rsum_nxt == dsum) bus.done  <= 1'b1;
            else                  bus.error <= 1'b1;
          end
        end
        CMP: begin
          bus.in_ready <= 1'b1;
          state        <= IDLE;
        end
        ERR: begin
          bus.in_ready <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
